// File: rtl/rpn_calc_core.sv
// rpn_calc_core: RPN calculator engine with hex digit entry, operand stack,
// a two-stage ALU sequence (EXEC, WB), error reporting and a display word.
module rpn_calc_core #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       reset_i,
   input  logic                       key_valid_i,
   input  logic                       key_cmd_i,
   input  logic [3:0]                 key_code_i,
   output logic                       busy_o,
   output logic [DATA_W-1:0]          disp_o,
   output logic [$clog2(DEPTH+1)-1:0] depth_o,
   output logic                       carry_o,
   output logic                       zero_o,
   output logic [2:0]                 codigo_error
);

   localparam int unsigned DW   = $clog2(DEPTH + 1);
   localparam int unsigned IW   = $clog2(DEPTH);
   localparam int unsigned NDIG = DATA_W / 4;
   localparam int unsigned CW   = $clog2(NDIG + 1);

   localparam logic [2:0] E_NONE  = 3'd0;
   localparam logic [2:0] E_FULL  = 3'd1;
   localparam logic [2:0] E_UNDER = 3'd2;
   localparam logic [2:0] E_OVF   = 3'd3;
   localparam logic [2:0] E_UNDEF = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   stack_q [DEPTH];
   logic [DATA_W-1:0]   stack_d [DEPTH];
   logic [DW-1:0]       depth_q, depth_d;
   logic [DATA_W-1:0]   entry_q, entry_d;
   logic [CW-1:0]       count_q, count_d;
   logic                active_q, active_d;
   logic                busy_q, busy_d;
   logic                carry_q, carry_d;
   logic                zero_q, zero_d;
   logic [2:0]          err_q, err_d;
   logic [DATA_W-1:0]   op_a_q, op_a_d;
   logic [DATA_W-1:0]   op_b_q, op_b_d;
   logic [3:0]          op_q, op_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic                res_cy_q, res_cy_d;
   logic [DATA_W-1:0]   disp_q, disp_d;
   logic [DATA_W:0]     alu_sum;

   // Key decode, ALU sequencing and display word selection
   always_comb begin
      state_d  = state_q;
      stack_d  = stack_q;
      depth_d  = depth_q;
      entry_d  = entry_q;
      count_d  = count_q;
      active_d = active_q;
      busy_d   = busy_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      err_d    = err_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      op_d     = op_q;
      res_d    = res_q;
      res_cy_d = res_cy_q;
      alu_sum  = {1'b0, op_a_q} + {1'b0, op_b_q};

      case (state_q)
         S_IDLE: begin
            if (key_valid_i) begin
               err_d = E_NONE;
               if (!key_cmd_i) begin
                  if (count_q == CW'(NDIG)) begin
                     err_d = E_OVF;
                  end else begin
                     entry_d  = {entry_q[DATA_W-5:0], key_code_i};
                     count_d  = count_q + CW'(1);
                     active_d = 1'b1;
                  end
               end else begin
                  case (key_code_i)
                     4'd0: begin
                        if (depth_q == DW'(DEPTH)) begin
                           err_d = E_FULL;
                        end else begin
                           stack_d[IW'(depth_q)] = entry_q;
                           depth_d  = depth_q + DW'(1);
                           entry_d  = '0;
                           count_d  = '0;
                           active_d = 1'b0;
                        end
                     end
                     4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
                        if (active_q && (depth_q == DW'(DEPTH))) begin
                           err_d = E_FULL;
                        end else begin
                           // pending entry becomes the B operand
                           if (active_q) begin
                              stack_d[IW'(depth_q)] = entry_q;
                              depth_d  = depth_q + DW'(1);
                              entry_d  = '0;
                              count_d  = '0;
                              active_d = 1'b0;
                           end
                           if (depth_d < DW'(2)) begin
                              err_d = E_UNDER;
                           end else begin
                              op_a_d  = stack_d[IW'(depth_d - DW'(2))];
                              op_b_d  = stack_d[IW'(depth_d - DW'(1))];
                              op_d    = key_code_i;
                              busy_d  = 1'b1;
                              state_d = S_EXEC;
                           end
                        end
                     end
                     4'd6: begin
                        if (depth_q == '0) err_d = E_UNDER;
                        else               depth_d = depth_q - DW'(1);
                     end
                     4'd7: begin
                        if (depth_q < DW'(2)) begin
                           err_d = E_UNDER;
                        end else begin
                           stack_d[IW'(depth_q - DW'(1))] = stack_q[IW'(depth_q - DW'(2))];
                           stack_d[IW'(depth_q - DW'(2))] = stack_q[IW'(depth_q - DW'(1))];
                        end
                     end
                     4'd15: begin
                        depth_d  = '0;
                        entry_d  = '0;
                        count_d  = '0;
                        active_d = 1'b0;
                        carry_d  = 1'b0;
                        zero_d   = 1'b0;
                     end
                     default: err_d = E_UNDEF;
                  endcase
               end
            end
         end
         S_EXEC: begin
            case (op_q)
               4'd1:    begin res_d = alu_sum[DATA_W-1:0]; res_cy_d = alu_sum[DATA_W]; end
               4'd2:    begin res_d = op_a_q - op_b_q;     res_cy_d = (op_a_q < op_b_q); end
               4'd3:    begin res_d = op_a_q & op_b_q;     res_cy_d = 1'b0; end
               4'd4:    begin res_d = op_a_q | op_b_q;     res_cy_d = 1'b0; end
               default: begin res_d = op_a_q ^ op_b_q;     res_cy_d = 1'b0; end
            endcase
            state_d = S_WB;
         end
         S_WB: begin
            stack_d[IW'(depth_q - DW'(2))] = res_q;
            depth_d = depth_q - DW'(1);
            carry_d = res_cy_q;
            zero_d  = (res_q == '0);
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (active_d)            disp_d = entry_d;
      else if (depth_d != '0)  disp_d = stack_d[IW'(depth_d - DW'(1))];
      else                     disp_d = '0;
   end

   // State and datapath registers; reset aborts any in-flight operation
   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         for (int i = 0; i < int'(DEPTH); i++) stack_q[i] <= '0;
         depth_q  <= '0;
         entry_q  <= '0;
         count_q  <= '0;
         active_q <= 1'b0;
         busy_q   <= 1'b0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         err_q    <= E_NONE;
         op_a_q   <= '0;
         op_b_q   <= '0;
         op_q     <= '0;
         res_q    <= '0;
         res_cy_q <= 1'b0;
         disp_q   <= '0;
      end else begin
         state_q  <= state_d;
         stack_q  <= stack_d;
         depth_q  <= depth_d;
         entry_q  <= entry_d;
         count_q  <= count_d;
         active_q <= active_d;
         busy_q   <= busy_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         op_q     <= op_d;
         res_q    <= res_d;
         res_cy_q <= res_cy_d;
         disp_q   <= disp_d;
      end
   end

   assign busy_o       = busy_q;
   assign disp_o       = disp_q;
   assign depth_o      = depth_q;
   assign carry_o      = carry_q;
   assign zero_o       = zero_q;
   assign codigo_error = err_q;

endmodule

// File: tb/tb_rpn_calc_core.sv
// tb_rpn_calc_core: directed keys into a 16-bit/8-deep and an 8-bit/4-deep
// core; expected results are queued by the stimulus and checked by a monitor.
module tb_rpn_calc_core;

   typedef struct packed {
      logic [15:0] disp;
      logic [3:0]  depth;
      logic [2:0]  err;
      logic        c;
      logic        z;
      logic [1:0]  bc;
   } exp_t;

   logic        clk = 1'b1;
   logic        rst_req = 1'b1;
   logic        sel = 1'b0;
   logic        kv = 1'b0;
   logic        kcmd = 1'b0;
   logic [3:0]  kcode = 4'd0;

   logic        rst16, rst8;
   logic        busy16, busy8, c16, c8, z16, z8;
   logic [15:0] disp16;
   logic [7:0]  disp8;
   logic [3:0]  depth16;
   logic [2:0]  depth8;
   logic [2:0]  err16, err8;

   logic [15:0] m_disp;
   logic [3:0]  m_depth;
   logic [2:0]  m_err;
   logic        m_c, m_z, m_busy;

   exp_t  exp_q[$];
   string nm_q[$];
   int    n_chk = 0;
   int    n_err = 0;
   logic  pend = 1'b0;
   int    bcnt = 0;

   always #5 clk = ~clk;

   // the unselected core is parked in reset
   assign rst16 = sel ? 1'b1 : rst_req;
   assign rst8  = sel ? rst_req : 1'b1;

   rpn_calc_core #(.DATA_W(16), .DEPTH(8)) u_dut16 (
      .clk(clk), .reset_i(rst16), .key_valid_i(kv), .key_cmd_i(kcmd),
      .key_code_i(kcode), .busy_o(busy16), .disp_o(disp16), .depth_o(depth16),
      .carry_o(c16), .zero_o(z16), .codigo_error(err16));

   rpn_calc_core #(.DATA_W(8), .DEPTH(4)) u_dut8 (
      .clk(clk), .reset_i(rst8), .key_valid_i(kv), .key_cmd_i(kcmd),
      .key_code_i(kcode), .busy_o(busy8), .disp_o(disp8), .depth_o(depth8),
      .carry_o(c8), .zero_o(z8), .codigo_error(err8));

   assign m_disp  = sel ? {8'h00, disp8} : disp16;
   assign m_depth = sel ? {1'b0, depth8} : depth16;
   assign m_err   = sel ? err8 : err16;
   assign m_c     = sel ? c8 : c16;
   assign m_z     = sel ? z8 : z16;
   assign m_busy  = sel ? busy8 : busy16;

   // Monitor: once an accepted key or reset settles (busy low), pop and compare
   always @(negedge clk) begin
      if (pend) begin
         if (m_busy && !rst_req) begin
            bcnt++;
            if (bcnt > 6) begin
               n_chk++; n_err++;
               $display("FAIL busy_timeout: busy still high after %0d cycles, required to drop after 2", bcnt);
               pend = 1'b0;
            end
         end else if (!m_busy) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL no_expect: response disp=%h with no queued expectation", m_disp);
            end else begin
               exp_t  e;
               string nm;
               e  = exp_q.pop_front();
               nm = nm_q.pop_front();
               if (m_disp !== e.disp || m_depth !== e.depth || m_err !== e.err ||
                   m_c !== e.c || m_z !== e.z || bcnt != int'(e.bc)) begin
                  n_err++;
                  $display("FAIL %s: got disp=%h depth=%0d err=%0d c=%b z=%b busy=%0d, required disp=%h depth=%0d err=%0d c=%b z=%b busy=%0d",
                           nm, m_disp, m_depth, m_err, m_c, m_z, bcnt,
                           e.disp, e.depth, e.err, e.c, e.z, e.bc);
               end
            end
            pend = 1'b0;
         end
      end
      if (rst_req || (kv && !m_busy)) begin
         pend = 1'b1;
         bcnt = 0;
      end
   end

   task automatic push(input string nm, input logic [15:0] d, input int dp,
                       input int er, input int c, input int z, input int bc);
      exp_t e;
      e.disp = d; e.depth = 4'(dp); e.err = 3'(er);
      e.c = 1'(c); e.z = 1'(z); e.bc = 2'(bc);
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic pulse(input logic cmd, input logic [3:0] code);
      kv = 1'b1; kcmd = cmd; kcode = code;
      @(posedge clk); #1;
      kv = 1'b0;
   endtask

   task automatic key(input logic cmd, input logic [3:0] code, input string nm,
                      input logic [15:0] d, input int dp, input int er,
                      input int c, input int z, input int bc);
      push(nm, d, dp, er, c, z, bc);
      pulse(cmd, code);
      if (bc > 0) repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic dg(input logic [3:0] v, input string nm, input logic [15:0] d,
                     input int dp, input int er, input int c, input int z);
      key(1'b0, v, nm, d, dp, er, c, z, 0);
   endtask

   task automatic cm(input logic [3:0] v, input string nm, input logic [15:0] d,
                     input int dp, input int er, input int c, input int z, input int bc);
      key(1'b1, v, nm, d, dp, er, c, z, bc);
   endtask

   task automatic rst();
      rst_req = 1'b1;
      push("reset", 16'h0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      rst_req = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (exp_q.size() != 0 || pend); i++) @(posedge clk);
      #1;
      if (exp_q.size() != 0 || pend) begin
         n_chk++; n_err++;
         $display("FAIL drain: %0d expectations still queued, required 0", exp_q.size());
         exp_q.delete(); nm_q.delete();
      end
   endtask

   initial begin
      // 16-bit / 8-deep core
      rst();
      dg(4'h1, "dig1", 16'h0001, 0, 0, 0, 0);
      dg(4'h2, "dig2", 16'h0012, 0, 0, 0, 0);
      dg(4'h3, "dig3", 16'h0123, 0, 0, 0, 0);
      dg(4'h4, "dig4", 16'h1234, 0, 0, 0, 0);
      dg(4'h5, "entry_ovf", 16'h1234, 0, 3, 0, 0);
      cm(4'hF, "clear1", 16'h0000, 0, 0, 0, 0, 0);
      dg(4'h0, "ff_d0", 16'h0000, 0, 0, 0, 0);
      dg(4'h0, "ff_d1", 16'h0000, 0, 0, 0, 0);
      dg(4'hF, "ff_d2", 16'h000F, 0, 0, 0, 0);
      dg(4'hF, "ff_d3", 16'h00FF, 0, 0, 0, 0);
      cm(4'h0, "ff_enter", 16'h00FF, 1, 0, 0, 0, 0);
      dg(4'h1, "one", 16'h0001, 1, 0, 0, 0);
      // ADD with key pulses landing in EXEC and WB, which must be dropped
      push("add_ff_1", 16'h0100, 1, 0, 0, 0, 2);
      pulse(1'b1, 4'h1);
      pulse(1'b0, 4'h7);
      pulse(1'b1, 4'h6);
      cm(4'hF, "clear2", 16'h0000, 0, 0, 0, 0, 0);
      dg(4'h1, "sub_d1", 16'h0001, 0, 0, 0, 0);
      cm(4'h0, "sub_e1", 16'h0001, 1, 0, 0, 0, 0);
      dg(4'h2, "sub_d2", 16'h0002, 1, 0, 0, 0);
      cm(4'h0, "sub_e2", 16'h0002, 2, 0, 0, 0, 0);
      cm(4'h2, "sub_borrow", 16'hFFFF, 1, 0, 1, 0, 2);
      dg(4'hF, "f1", 16'h000F, 1, 0, 1, 0);
      dg(4'hF, "f2", 16'h00FF, 1, 0, 1, 0);
      dg(4'hF, "f3", 16'h0FFF, 1, 0, 1, 0);
      dg(4'hF, "f4", 16'hFFFF, 1, 0, 1, 0);
      cm(4'h0, "f_enter", 16'hFFFF, 2, 0, 1, 0, 0);
      dg(4'h0, "zero_dig", 16'h0000, 2, 0, 1, 0);
      cm(4'h3, "and_zero", 16'h0000, 2, 0, 0, 1, 2);
      cm(4'h7, "swap", 16'hFFFF, 2, 0, 0, 1, 0);
      cm(4'h6, "drop", 16'h0000, 1, 0, 0, 1, 0);
      cm(4'h7, "swap_under", 16'h0000, 1, 2, 0, 1, 0);
      cm(4'h6, "drop_last", 16'h0000, 0, 0, 0, 1, 0);
      cm(4'h6, "drop_under", 16'h0000, 0, 2, 0, 1, 0);
      cm(4'h9, "undef_cmd", 16'h0000, 0, 4, 0, 1, 0);
      cm(4'h1, "add_empty", 16'h0000, 0, 2, 0, 1, 0);
      dg(4'h3, "lone_dig", 16'h0003, 0, 0, 0, 1);
      cm(4'h1, "add_push_under", 16'h0003, 1, 2, 0, 1, 0);
      cm(4'hF, "clear3", 16'h0000, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         dg(4'(i), "fill_dig", 16'(i), i - 1, 0, 0, 0);
         cm(4'h0, "fill_enter", 16'(i), i, 0, 0, 0, 0);
      end
      cm(4'h0, "full_enter", 16'h0008, 8, 1, 0, 0, 0);
      dg(4'hA, "err_cleared", 16'h000A, 8, 0, 0, 0);
      cm(4'h0, "full_enter_entry", 16'h000A, 8, 1, 0, 0, 0);
      cm(4'h1, "full_implicit_add", 16'h000A, 8, 1, 0, 0, 0);
      cm(4'hF, "clear4", 16'h0000, 0, 0, 0, 0, 0);
      // reset lands in WB of an ADD; no writeback may survive it
      dg(4'h1, "wb_d1", 16'h0001, 0, 0, 0, 0);
      cm(4'h0, "wb_e1", 16'h0001, 1, 0, 0, 0, 0);
      dg(4'h2, "wb_d2", 16'h0002, 1, 0, 0, 0);
      pulse(1'b1, 4'h1);
      @(posedge clk); #1;
      rst();
      dg(4'h5, "after_rst", 16'h0005, 0, 0, 0, 0);
      drain();

      // 8-bit / 4-deep core
      sel = 1'b1;
      rst();
      dg(4'hF, "n_f1", 16'h000F, 0, 0, 0, 0);
      dg(4'hF, "n_f2", 16'h00FF, 0, 0, 0, 0);
      cm(4'h0, "n_enter", 16'h00FF, 1, 0, 0, 0, 0);
      dg(4'h0, "n_d0", 16'h0000, 1, 0, 0, 0);
      dg(4'h1, "n_d1", 16'h0001, 1, 0, 0, 0);
      cm(4'h1, "n_add_wrap", 16'h0000, 1, 0, 1, 1, 2);
      dg(4'h3, "n_d3", 16'h0003, 1, 0, 1, 1);
      dg(4'h4, "n_d4", 16'h0034, 1, 0, 1, 1);
      dg(4'h5, "n_ovf", 16'h0034, 1, 3, 1, 1);
      cm(4'h0, "n_e2", 16'h0034, 2, 0, 1, 1, 0);
      cm(4'h0, "n_e3", 16'h0000, 3, 0, 1, 1, 0);
      cm(4'h0, "n_e4", 16'h0000, 4, 0, 1, 1, 0);
      cm(4'h0, "n_full", 16'h0000, 4, 1, 1, 1, 0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
